kyber_mod_reduce_pipe: RTL

Streaming conditional-subtract reducer that sits directly downstream of the 13-bit carry-look-ahead coefficient adder. It accepts raw sums in the range 0..2Q-1 and emits coefficients reduced mod Q (Kyber Q = 3329). It has a 2-stage valid/ready pipeline with full backpressure, a sticky range-error flag and an output coefficient counter. It feeds the polynomial buffer / NTT write port.

---
 rtl/kyber_pkg.sv | 11 +
 rtl/cond_sub_q.sv | 19 +
 rtl/kyber_mod_reduce_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and coefficient types used by the
// coefficient datapath blocks.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 12;

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [COEF_W:0]   sum_t;

endpackage

// File: rtl/cond_sub_q.sv
// Combinational trial subtraction of Q from a raw sum; the borrow tells the
// caller whether the sum was already below Q.
module cond_sub_q
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  sum_t              sum,
  output logic [COEF_W+1:0] diff,
  output logic              borrow
);

  localparam logic [COEF_W+1:0] Q_EXT = Q[COEF_W+1:0];

  // One extra bit of headroom so the MSB of the difference is a clean borrow.
  assign diff   = {1'b0, sum} - Q_EXT;
  assign borrow = diff[COEF_W+1];

endmodule

// File: rtl/kyber_mod_reduce_pipe.sv
// Two-stage valid/ready reducer mapping raw adder sums (0..2Q-1) to
// coefficients mod Q, with a sticky range error and output counter.
module kyber_mod_reduce_pipe
  import kyber_pkg::*;
#(
  parameter int DATA_WID = COEF_W,
  parameter int Q        = KYBER_Q,
  parameter int CNT_WID  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [DATA_WID:0]   in_sum,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_WID-1:0] out_coef,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                range_err,
  output logic [CNT_WID-1:0]  out_count
);

  localparam logic [DATA_WID:0]  Q_LOW = Q[DATA_WID:0];
  localparam logic [CNT_WID-1:0] CNT_ONE = {{(CNT_WID-1){1'b0}}, 1'b1};

  logic [DATA_WID+1:0] diff;
  logic                borrow;
  logic                range_hit;

  logic                s1_valid;
  logic [DATA_WID-1:0] s1_sum;
  logic [DATA_WID-1:0] s1_diff;
  logic                s1_borrow;
  logic                s1_range;

  logic s2_free;
  logic s1_free;
  logic s1_adv;
  logic in_xfer;
  logic out_xfer;

  cond_sub_q #(
    .Q(Q)
  ) u_cond_sub_q (
    .sum   (in_sum),
    .diff  (diff),
    .borrow(borrow)
  );

  // sum >= 2Q is the same as (sum - Q) being non-negative and still >= Q.
  assign range_hit = !diff[DATA_WID+1] && (diff[DATA_WID:0] >= Q_LOW);

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign s1_free  = !s1_valid || s2_free;
  assign in_ready = s1_free && !clear && rst_n;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_diff   <= '0;
      s1_borrow <= 1'b0;
      s1_range  <= 1'b0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      range_err <= 1'b0;
      out_count <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      range_err <= 1'b0;
      out_count <= '0;
    end else begin
      if (s1_free) begin
        s1_valid <= in_xfer;
      end
      if (in_xfer) begin
        s1_sum    <= in_sum[DATA_WID-1:0];
        s1_diff   <= diff[DATA_WID-1:0];
        s1_borrow <= borrow;
        s1_range  <= range_hit;
      end
      if (s2_free) begin
        out_valid <= s1_valid;
      end
      // Out-of-range sums keep the single subtraction, truncated.
      if (s1_adv) begin
        out_coef <= s1_borrow ? s1_sum : s1_diff;
        if (s1_range) begin
          range_err <= 1'b1;
        end
      end
      if (out_xfer) begin
        out_count <= out_count + CNT_ONE;
      end
    end
  end

endmodule
